// File: rtl/grid_frame_scanner.sv
// grid_frame_scanner: walks a GRID_W x GRID_H playfield one cell per cycle,
// priority-encodes the object at each cell and sends a draw command to the
// display engine for changed cells (differential) or all cells (full redraw).
// A shadow memory holds the last drawn frame. Game steps are paced by tick.
module grid_frame_scanner #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          head,
  input  logic          body,
  input  logic          apple,
  input  logic          border,
  input  logic          tick,
  input  logic          game_over,
  input  logic          mode_pb,
  input  logic          cmd_done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [2:0]    obj_code,
  output logic          cmd_valid,
  output logic          cmd_clear,
  output logic          en_update,
  output logic          frame_done,
  output logic          sync_reset,
  output logic          full_mode
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IW    = $clog2(CELLS);

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_SCAN     = 3'd2;
  localparam logic [2:0] S_WAIT_CMD = 3'd3;
  localparam logic [2:0] S_UPDATE   = 3'd4;
  localparam logic [2:0] S_OVER     = 3'd5;

  localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);
  localparam logic [IW-1:0] W_IDX  = IW'(GRID_W);

  // Priority encoder: head > body > apple > border > empty.
  function automatic logic [2:0] encode_obj(input logic h, input logic b,
                                            input logic a, input logic r);
    logic [2:0] c;
    if (h) begin
      c = 3'd4;
    end else if (b) begin
      c = 3'd3;
    end else if (a) begin
      c = 3'd2;
    end else if (r) begin
      c = 3'd1;
    end else begin
      c = 3'd0;
    end
    return c;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    obj_code_q, obj_code_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_clear_q, cmd_clear_d;
  logic          en_update_q, en_update_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_reset_q, sync_reset_d;
  logic          full_mode_q, full_mode_d;
  logic          frame_mode_q, frame_mode_d;
  logic          over_flag_q, over_flag_d;

  logic [2:0]    shadow_q [CELLS];
  logic [IW-1:0] idx_s;
  logic [2:0]    shadow_rd_s;
  logic          shadow_we_s;
  logic [2:0]    shadow_wdata_s;
  logic [2:0]    code_s;
  logic          last_cell_s;
  logic [XW-1:0] next_x_s;
  logic [YW-1:0] next_y_s;

  assign idx_s       = IW'(y_q) * W_IDX + IW'(x_q);
  assign shadow_rd_s = shadow_q[idx_s];
  assign code_s      = encode_obj(head, body, apple, border);
  assign last_cell_s = (x_q == X_LAST) && (y_q == Y_LAST);
  assign next_x_s    = (x_q == X_LAST) ? {XW{1'b0}} : x_q + XW'(1);
  assign next_y_s    = (x_q == X_LAST) ? y_q + YW'(1) : y_q;

  // Next-state and output decode for the scan / handshake / pacing FSM.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    obj_code_d     = obj_code_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_clear_d    = cmd_clear_q;
    en_update_d    = 1'b0;
    frame_done_d   = 1'b0;
    sync_reset_d   = 1'b0;
    shadow_we_s    = 1'b0;
    shadow_wdata_s = 3'd0;
    frame_mode_d   = frame_mode_q;
    over_flag_d    = over_flag_q | game_over;
    // The button toggles the mode everywhere but OVER, where it restarts.
    full_mode_d    = full_mode_q ^ (mode_pb && (state_q != S_OVER));
    case (state_q)
      S_INIT: begin
        shadow_we_s    = 1'b1;
        shadow_wdata_s = 3'd0;
        over_flag_d    = 1'b0;
        if (last_cell_s) begin
          x_d         = {XW{1'b0}};
          y_d         = {YW{1'b0}};
          obj_code_d  = 3'd0;
          cmd_valid_d = 1'b1;
          cmd_clear_d = 1'b1;
          state_d     = S_CLEAR;
        end else begin
          x_d = next_x_s;
          y_d = next_y_s;
        end
      end
      S_CLEAR: begin
        if (cmd_done) begin
          cmd_valid_d  = 1'b0;
          cmd_clear_d  = 1'b0;
          frame_mode_d = full_mode_d;
          state_d      = S_SCAN;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_SCAN: begin
        if (frame_mode_q || (code_s != shadow_rd_s)) begin
          obj_code_d  = code_s;
          cmd_valid_d = 1'b1;
          state_d     = S_WAIT_CMD;
        end else if (last_cell_s) begin
          x_d          = {XW{1'b0}};
          y_d          = {YW{1'b0}};
          frame_done_d = 1'b1;
          state_d      = S_UPDATE;
        end else begin
          x_d = next_x_s;
          y_d = next_y_s;
        end
      end
      S_WAIT_CMD: begin
        if (cmd_done) begin
          shadow_we_s    = 1'b1;
          shadow_wdata_s = obj_code_q;
          cmd_valid_d    = 1'b0;
          if (last_cell_s) begin
            x_d          = {XW{1'b0}};
            y_d          = {YW{1'b0}};
            frame_done_d = 1'b1;
            state_d      = S_UPDATE;
          end else begin
            x_d     = next_x_s;
            y_d     = next_y_s;
            state_d = S_SCAN;
          end
        end else begin
          state_d = S_WAIT_CMD;
        end
      end
      S_UPDATE: begin
        if (tick && over_flag_d) begin
          obj_code_d  = 3'd0;
          cmd_valid_d = 1'b0;
          cmd_clear_d = 1'b0;
          state_d     = S_OVER;
        end else if (tick) begin
          en_update_d  = 1'b1;
          frame_mode_d = full_mode_d;
          state_d      = S_SCAN;
        end else begin
          state_d = S_UPDATE;
        end
      end
      S_OVER: begin
        obj_code_d  = 3'd0;
        cmd_valid_d = 1'b0;
        cmd_clear_d = 1'b0;
        if (mode_pb) begin
          sync_reset_d = 1'b1;
          x_d          = {XW{1'b0}};
          y_d          = {YW{1'b0}};
          state_d      = S_INIT;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        obj_code_d  = 3'd0;
        cmd_valid_d = 1'b0;
        cmd_clear_d = 1'b0;
        x_d         = {XW{1'b0}};
        y_d         = {YW{1'b0}};
        state_d     = S_INIT;
      end
    endcase
  end

  // State and registered outputs; async reset abandons any command in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_INIT;
      x_q          <= {XW{1'b0}};
      y_q          <= {YW{1'b0}};
      obj_code_q   <= 3'd0;
      cmd_valid_q  <= 1'b0;
      cmd_clear_q  <= 1'b0;
      en_update_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_reset_q <= 1'b0;
      full_mode_q  <= 1'b0;
      frame_mode_q <= 1'b0;
      over_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      obj_code_q   <= obj_code_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_clear_q  <= cmd_clear_d;
      en_update_q  <= en_update_d;
      frame_done_q <= frame_done_d;
      sync_reset_q <= sync_reset_d;
      full_mode_q  <= full_mode_d;
      frame_mode_q <= frame_mode_d;
      over_flag_q  <= over_flag_d;
    end
  end

  // Shadow frame memory write port; contents are defined once INIT has run.
  always_ff @(posedge clk) begin
    if (shadow_we_s) begin
      shadow_q[idx_s] <= shadow_wdata_s;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign obj_code   = obj_code_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_clear  = cmd_clear_q;
  assign en_update  = en_update_q;
  assign frame_done = frame_done_q;
  assign sync_reset = sync_reset_q;
  assign full_mode  = full_mode_q;

endmodule

// File: tb/tb_grid_frame_scanner.sv
// Bench for grid_frame_scanner: a 16x16 instance driven from a playfield
// array with a command scoreboard, plus a 10x6 instance for wrap checks.
module tb_grid_frame_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 16x16 instance ----------------
  logic       nrst_a, head_a, body_a, apple_a, border_a;
  logic       tick_a, go_a, pb_a, done_a;
  logic [3:0] xa, ya;
  logic [2:0] obj_a;
  logic       valid_a, clear_a, enu_a, fd_a, sr_a, fm_a;
  logic [3:0] field_a [256];

  assign {head_a, body_a, apple_a, border_a} = field_a[{ya, xa}];

  grid_frame_scanner #(.GRID_W(16), .GRID_H(16)) dut_a (
    .clk(clk), .nrst(nrst_a), .head(head_a), .body(body_a), .apple(apple_a),
    .border(border_a), .tick(tick_a), .game_over(go_a), .mode_pb(pb_a),
    .cmd_done(done_a), .x(xa), .y(ya), .obj_code(obj_a), .cmd_valid(valid_a),
    .cmd_clear(clear_a), .en_update(enu_a), .frame_done(fd_a),
    .sync_reset(sr_a), .full_mode(fm_a)
  );

  // ---------------- 10x6 instance ----------------
  logic       nrst_b, done_b, border_b;
  logic [3:0] xb;
  logic [2:0] yb;
  logic [2:0] obj_b;
  logic       valid_b, clear_b, enu_b, fd_b, sr_b, fm_b;

  assign border_b = (xb == 4'd9) && (yb == 3'd5);

  grid_frame_scanner #(.GRID_W(10), .GRID_H(6)) dut_b (
    .clk(clk), .nrst(nrst_b), .head(1'b0), .body(1'b0), .apple(1'b0),
    .border(border_b), .tick(1'b0), .game_over(1'b0), .mode_pb(1'b0),
    .cmd_done(done_b), .x(xb), .y(yb), .obj_code(obj_b), .cmd_valid(valid_b),
    .cmd_clear(clear_b), .en_update(enu_b), .frame_done(fd_b),
    .sync_reset(sr_b), .full_mode(fm_b)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  typedef struct { int idx; int code; } exp_t;
  exp_t sb [$];

  typedef struct {
    int cx; int cy; logic [3:0] flags;
    int dly; int pb_at; int spur_at; int exp_cnt; int exp_code;
  } vec_t;
  vec_t vt [7];

  logic [2:0] shadow_m [256];
  bit full_m;
  int ncmd;
  int tgt_x, tgt_y, obs_code;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int prio(input logic [3:0] f);
    if (f[3]) return 4;
    else if (f[2]) return 3;
    else if (f[1]) return 2;
    else if (f[0]) return 1;
    else return 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Push the commands a frame must produce, in raster order.
  task automatic plan_frame(input bit fm);
    int c;
    for (int i = 0; i < 256; i++) begin
      c = prio(field_a[i]);
      if (fm || (c != int'(shadow_m[i]))) begin
        sb.push_back('{i, c});
        shadow_m[i] = 3'(c);
      end
    end
  endtask

  task automatic handle_cmd(input int dly);
    exp_t e;
    int x0, y0, o0;
    bit stable;
    ncmd++;
    chk("sb_has_entry", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cmd_x", int'(xa), e.idx % 16);
      chk("cmd_y", int'(ya), e.idx / 16);
      chk("cmd_code", int'(obj_a), e.code);
    end
    if ((int'(xa) == tgt_x) && (int'(ya) == tgt_y)) obs_code = int'(obj_a);
    x0 = int'(xa); y0 = int'(ya); o0 = int'(obj_a); stable = 1'b1;
    for (int k = 0; k < dly; k++) begin
      cyc();
      if (int'(xa) != x0 || int'(ya) != y0 || int'(obj_a) != o0 || !valid_a)
        stable = 1'b0;
    end
    if (dly > 0) chk("hold_stable", int'(stable), 1);
    done_a = 1'b1;
    cyc();
    done_a = 1'b0;
    chk("valid_fall", int'(valid_a), 0);
  endtask

  task automatic run_frame(input int dly, input int pb_at, input int spur_at,
                           input int go_at);
    int guard;
    bit seen;
    bit pulsed;
    guard = 0; seen = 1'b0; ncmd = 0;
    while (!seen && guard < 2000 && ncmd < 300) begin
      if (valid_a) begin
        handle_cmd(dly);
      end else begin
        pulsed = (guard == pb_at);
        pb_a   = pulsed;
        done_a = (guard == spur_at);
        go_a   = (guard == go_at);
        if (pulsed) full_m = ~full_m;
        cyc();
        pb_a = 1'b0; done_a = 1'b0; go_a = 1'b0;
        if (pulsed) chk("mode_toggle", int'(fm_a), int'(full_m));
        guard++;
      end
      if (fd_a) seen = 1'b1;
    end
    chk("frame_done_seen", int'(seen), 1);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    cyc();
    chk("frame_done_pulse", int'(fd_a), 0);
  endtask

  task automatic do_tick();
    plan_frame(full_m);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    chk("en_update", int'(enu_a), 1);
  endtask

  task automatic count_init_a(input int start, input int exp);
    int n;
    n = start;
    while (!valid_a && n < 1000) begin
      cyc();
      n++;
    end
    chk("init_cycles", n, exp);
  endtask

  task automatic clear_handshake();
    chk("clear_valid", int'(valid_a), 1);
    chk("clear_flag", int'(clear_a), 1);
    chk("clear_code", int'(obj_a), 0);
    plan_frame(full_m);
    repeat (3) cyc();
    done_a = 1'b1;
    cyc();
    done_a = 1'b0;
    chk("clear_fall", int'({valid_a, clear_a}), 0);
  endtask

  initial begin
    int n;
    int bad;
    nrst_a = 1'b0; tick_a = 1'b0; go_a = 1'b0; pb_a = 1'b0; done_a = 1'b0;
    nrst_b = 1'b0; done_b = 1'b0;
    full_m = 1'b0;
    for (int i = 0; i < 256; i++) begin
      field_a[i] = 4'd0;
      shadow_m[i] = 3'd0;
    end
    vt[0] = '{3, 5, 4'b0010, 0, -1, -1, 1, 2};
    vt[1] = '{3, 5, 4'b0010, 0, -1, 30, 0, -1};
    vt[2] = '{3, 5, 4'b0010, 0, 20, -1, 0, -1};
    vt[3] = '{0, 0, 4'b1100, 0, 20, -1, 256, 4};
    vt[4] = '{0, 0, 4'b0100, 7, -1, -1, 1, 3};
    vt[5] = '{0, 0, 4'b0000, 1, -1, -1, 1, 0};
    vt[6] = '{15, 15, 4'b0001, 2, -1, -1, 1, 1};

    repeat (3) cyc();
    chk("rst_outputs_a",
        int'({xa, ya, obj_a, valid_a, clear_a, enu_a, fd_a, sr_a, fm_a}), 0);
    chk("rst_outputs_b",
        int'({xb, yb, obj_b, valid_b, clear_b, enu_b, fd_b, sr_b, fm_b}), 0);

    // Reset release, INIT length, clear command, first (empty) frame.
    nrst_a = 1'b1;
    count_init_a(0, 256);
    chk("init_xy", int'({xa, ya}), 0);
    clear_handshake();
    tgt_x = -1; tgt_y = -1;
    run_frame(0, -1, -1, -1);
    chk("empty_frame_cmds", ncmd, 0);

    // Table of frames: one cell edited per frame.
    for (int i = 0; i < 7; i++) begin
      field_a[vt[i].cy * 16 + vt[i].cx] = vt[i].flags;
      tgt_x = vt[i].cx; tgt_y = vt[i].cy; obs_code = -1;
      do_tick();
      run_frame(vt[i].dly, vt[i].pb_at, vt[i].spur_at, -1);
      chk("vec_cmd_count", ncmd, vt[i].exp_cnt);
      chk("vec_cell_code", obs_code, vt[i].exp_code);
    end

    // game_over mid-frame: frame completes, next tick enters OVER.
    field_a[5 * 16 + 5] = 4'b0010;
    tgt_x = 5; tgt_y = 5; obs_code = -1;
    do_tick();
    run_frame(1, -1, -1, 10);
    chk("over_frame_cmds", ncmd, 1);
    chk("over_frame_code", obs_code, 2);
    repeat (3) begin
      cyc();
      chk("update_idle", int'(enu_a), 0);
    end
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    chk("over_no_update", int'(enu_a), 0);
    chk("over_cmd_outputs", int'({obj_a, valid_a, clear_a}), 0);
    cyc();
    pb_a = 1'b1;
    cyc();
    pb_a = 1'b0;
    chk("sync_reset_pulse", int'(sr_a), 1);
    chk("full_mode_kept", int'(fm_a), int'(full_m));
    cyc();
    chk("sync_reset_width", int'(sr_a), 0);
    count_init_a(1, 256);
    for (int i = 0; i < 256; i++) shadow_m[i] = 3'd0;
    clear_handshake();
    tgt_x = -1; tgt_y = -1;
    run_frame(0, -1, -1, -1);
    chk("restart_frame_cmds", ncmd, 3);
    do_tick();
    run_frame(0, -1, -1, -1);
    chk("restart_quiet_frame", ncmd, 0);

    // 10x6 instance: INIT length, raster wrap at x=9 / y=5.
    nrst_b = 1'b1;
    n = 0;
    while (!valid_b && n < 1000) begin
      cyc();
      n++;
    end
    chk("b_init_cycles", n, 60);
    chk("b_clear_flag", int'(clear_b), 1);
    done_b = 1'b1;
    cyc();
    done_b = 1'b0;
    chk("b_clear_fall", int'(valid_b), 0);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (int'(xb) != k % 10 || int'(yb) != k / 10 || valid_b) bad++;
      cyc();
    end
    chk("b_raster_errors", bad, 0);
    chk("b_cmd_valid", int'(valid_b), 1);
    chk("b_cmd_xy", int'({xb, 1'b0, yb}), int'({4'd9, 1'b0, 3'd5}));
    chk("b_cmd_code", int'(obj_b), 1);
    done_b = 1'b1;
    cyc();
    done_b = 1'b0;
    chk("b_frame_done", int'({fd_b, xb, yb, valid_b}), int'({1'b1, 4'd0, 3'd0, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
